rr_mux_n_w: RTL
===============

Name: rr_mux_n_w

Overview:
Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake. It is the successor of the combinational 4:1 byte mux. It selects one requesting input channel per cycle, either by an explicit select (fixed mode) or by round-robin arbitration. The chosen word goes into a one-deep output register with a ready/valid interface. It sits between several byte/word producers and a single shared consumer such as a bus or display path.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel in bits (1..64)
SELW, $clog2(N), select/channel-index width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W]
in_valid  input  N  channel i has a word this cycle
in_ready  output  N  one-hot; channel i word consumed this cycle
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
out_data  output  W  registered selected word
out_chan  output  SELW  index of the channel that supplied out_data
out_valid  output  1  out_data/out_chan hold a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer last=N-1, so channel 0 has top priority first.
  - in_ready=0 while rst=1.
  - A word held at reset is dropped. No handshake completes in a reset cycle.
- load_en = !out_valid || out_ready. The register accepts a new word whenever it is empty or being drained the same cycle. This gives full throughput: 1 word/cycle.
- Fixed mode (mode=0):
  - grant = sel, grant_v = in_valid[sel].
  - If sel >= N (N not a power of 2), grant_v=0.
- Round-robin mode (mode=1):
  - Search channels last+1, last+2, ... modulo N.
  - grant = first channel with in_valid set; grant_v = |in_valid.
- in_ready[i] = load_en && grant_v && (grant==i). This is purely combinational from in_valid, sel, mode, out_valid, out_ready and last. Never more than one bit is set.
- On a clk edge with load_en && grant_v:
  - out_data <= selected word, out_chan <= grant, out_valid <= 1.
  - If mode=1, last <= grant.
- On a clk edge with load_en && !grant_v: out_valid <= 0. out_data and out_chan hold their old values.
- Latency: input handshake at edge k means the word is visible on out_data after edge k, valid from cycle k+1.
- Backpressure: while out_valid && !out_ready, out_data, out_chan and out_valid hold stable and all in_ready=0.
- Pointer update:
  - last updates only on RR transfers.
  - Fixed-mode transfers leave last unchanged.
  - A mode switch takes effect at the next arbitration with no flush.
- Wrap-around: when last=N-1, the search starts at channel 0.
- Fairness: with all N channels continuously valid in RR mode, grants cycle 0,1,...,N-1,0 with no channel granted twice within N transfers.
- Changes to sel while the output is stalled affect only the next load, never the held word.

Decomposition:
- Shared package holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function or constant for SELW computation, shared with other muxes in the codebase.
- One sub-module is natural: rr_grant. It is combinational and parametrised by N. Inputs: req[N], last[SELW]. Outputs: grant[SELW], grant_v.
  - Implemented as a rotate, fixed-priority pick, and rotate back.
- The top level contains the output register, the pointer and the handshake logic.

Test Plan:
- Reset, default N=4, W=8: hold rst for 2 cycles with all inputs valid → out_valid=0, out_data=0, out_chan=0, in_ready=0000 throughout.
- Fixed mode, out_ready=1: ch3..0 = 2,5,6,7 all valid; sweep sel 0,1,2,3 one per cycle → out_data 7,6,5,2 each one cycle after its sel; in_ready one-hot 0001,0010,0100,1000.
- Round-robin, all valid, out_ready=1, same data → out_chan sequence 0,1,2,3,0; out_data 7,6,5,2,7; one word per cycle.
- RR wrap and skip: valid=1001 after a grant to ch3 → next grant ch0 (data 7), then ch3 (data 2); channels 1 and 2 are never granted.
- Backpressure: out_ready=0 for 3 cycles after a load of 6 from ch1 → out_data=6, out_chan=1, out_valid=1 held; in_ready=0000; the pointer does not advance. Raising out_ready gives the next word the following cycle.
- Reset mid-operation: rst asserted while out_valid=1 and stalled → next cycle out_valid=0. The first RR grant after reset goes to channel 0.

Source files
------------

// File: rtl/rr_mux_n_w_pkg.sv
// Shared definitions for the channel multiplexers: mode encodings and the
// channel-index width helper used to size select and grant ports.
package rr_mux_n_w_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // A single channel still needs one select bit, so never return zero.
   function automatic int rr_selw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant picker: rotates requests so the channel after 'last'
// sits at position 0, picks the lowest set bit, then maps back to a channel.
module rr_grant
   import rr_mux_n_w_pkg::*;
#(
   parameter  int N    = 4,
   localparam int SELW = rr_selw(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] last,
   output logic [SELW-1:0] grant,
   output logic            grant_v
);

   logic [N-1:0]    rotReq;
   logic [SELW-1:0] pickOff;

   function automatic logic [SELW-1:0] wrapIdx(input logic [SELW-1:0] base, input int off);
      int s;
      s = (int'(base) + off) % N;
      return SELW'(s);
   endfunction

   always_comb begin
      rotReq = '0;
      for (int j = 0; j < N; j++) begin
         rotReq[j] = req[wrapIdx(last, j + 1)];
      end
   end

   // Scanning downwards leaves the lowest requesting offset, i.e. the
   // channel closest after the previous winner.
   always_comb begin
      pickOff = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rotReq[j]) begin
            pickOff = SELW'(j);
         end
      end
   end

   always_comb begin
      grant   = wrapIdx(last, int'(pickOff) + 1);
      grant_v = |req;
   end

endmodule

// File: rtl/rr_mux_n_w.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes on every
// input and a one-deep output register; fixed-select or round-robin arbitration.
module rr_mux_n_w
   import rr_mux_n_w_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int W    = 8,
   localparam int SELW = rr_selw(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_chan,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int NPOW = 2 ** SELW;

   logic            outValid_q, outValid_d;
   logic [W-1:0]    outData_q, outData_d;
   logic [SELW-1:0] outChan_q, outChan_d;
   logic [SELW-1:0] last_q, last_d;

   logic            loadEn;
   logic [SELW-1:0] rrGrant;
   logic            rrGrantV;
   logic [SELW-1:0] grant;
   logic            grantV;
   logic [W-1:0]    selWord;
   logic [NPOW-1:0] validExt;

   rr_grant #(.N(N)) uGrant (
      .req     (in_valid),
      .last    (last_q),
      .grant   (rrGrant),
      .grant_v (rrGrantV)
   );

   assign loadEn = !outValid_q || out_ready;

   // Padding the valid vector to a power of two makes an out-of-range fixed
   // select read as "not valid" instead of indexing past the port.
   always_comb begin
      validExt         = '0;
      validExt[N-1:0]  = in_valid;
   end

   always_comb begin
      if (mode == MODE_RR) begin
         grant  = rrGrant;
         grantV = rrGrantV;
      end else begin
         grant  = sel;
         grantV = validExt[sel];
      end
   end

   always_comb begin
      selWord = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            selWord = in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (!rst && loadEn && grantV && (grant == SELW'(i))) begin
            in_ready[i] = 1'b1;
         end
      end
   end

   // An empty load slot with no grant drains the register but keeps the
   // last word and channel visible on the data lines.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outChan_d  = outChan_q;
      last_d     = last_q;
      if (loadEn) begin
         if (grantV) begin
            outValid_d = 1'b1;
            outData_d  = selWord;
            outChan_d  = grant;
            if (mode == MODE_RR) begin
               last_d = grant;
            end
         end else begin
            outValid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outChan_q  <= '0;
         last_q     <= SELW'(N - 1);
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outChan_q  <= outChan_d;
         last_q     <= last_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_chan  = outChan_q;

endmodule
